// File: rtl/ftdi_link_pkg.sv
// Shared types and widths for the FT2232H link scheduler: state encoding, owner encoding,
// byte and statistics widths, and a saturating counter helper.
package ftdi_link_pkg;

    localparam int BYTE_W = 8;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_WAIT = 2'd1,
        ST_RX_WAIT = 2'd2
    } link_state_t;

    typedef enum logic {
        OWN_TX = 1'b0,
        OWN_RX = 1'b1
    } link_owner_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/link_byte_fifo.sv
// Synchronous first-word-fall-through byte queue; head is valid whenever empty is low.
// DEPTH must be a power of two so the pointers wrap naturally.
module link_byte_fifo
    import ftdi_link_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count/empty guarantee stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ftdi_link_scheduler.sv
// Time-shares the half-duplex FT2232H byte link between a queued TX stream and an RX poller.
// Define FTDI_LINK_STATS_EN to build the saturating error/drop statistics counters.
module ftdi_link_scheduler
    import ftdi_link_pkg::*;
#(
    parameter int TXQ_DEPTH   = 4,
    parameter int BURST_LEN   = 2,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              tx_valid_i,
    input  logic [BYTE_W-1:0] tx_data_i,
    output logic              tx_ready_o,
    output logic              tx_drop_o,
    input  logic              rx_req_i,
    output logic              rx_valid_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_err_o,
    output logic              link_tx_rdy_o,
    output logic [BYTE_W-1:0] link_tx_data_o,
    input  logic              link_tx_ok_i,
    input  logic              link_tx_err_i,
    output logic              link_rx_poll_o,
    input  logic              link_rx_rdy_i,
    input  logic [BYTE_W-1:0] link_rx_data_i,
    input  logic              link_rx_err_i,
    input  logic              link_busy_i,
    input  logic              stats_clr_i,
    output logic [STAT_W-1:0] stat_txerr_o,
    output logic [STAT_W-1:0] stat_rxerr_o,
    output logic [STAT_W-1:0] stat_drop_o
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] BURST_TOP = BW'(BURST_LEN);
    localparam logic [RW-1:0] RETRY_TOP = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    link_state_t       state_q, state_d;
    link_owner_t       owner_q, owner_d;
    link_owner_t       grant_owner;
    logic [BW-1:0]     burst_q, burst_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic              drop_q, drop_d;
    logic              run_q;
    logic              tx_cand, rx_cand, keep_owner, timed_out;
    logic              tx_req, rx_poll, tx_fail, rx_fail;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BYTE_W-1:0] fifo_head;
    logic [$clog2(TXQ_DEPTH):0] fifo_count_unused;

    link_byte_fifo #(.DEPTH(TXQ_DEPTH)) u_txq (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .push      (fifo_push),
        .push_data (tx_data_i),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    // run_q holds every request and ready output low until the first edge after reset release.
    assign tx_ready_o = run_q && !fifo_full;
    assign fifo_push  = tx_valid_i && tx_ready_o;
    assign tx_cand    = !fifo_empty;
    assign rx_cand    = rx_req_i;
    assign timed_out  = (tmo_q == TMO_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_d     = burst_q;
        retry_d     = retry_q;
        tmo_d       = '0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;
        drop_d      = 1'b0;
        fifo_pop    = 1'b0;
        tx_req      = 1'b0;
        rx_poll     = 1'b0;
        tx_fail     = 1'b0;
        rx_fail     = 1'b0;
        keep_owner  = 1'b0;
        grant_owner = OWN_TX;

        case (state_q)
            ST_IDLE: begin
                if (run_q && !link_busy_i && (tx_cand || rx_cand)) begin
                    // A zero burst count means nobody owns the link yet, so the tie goes to
                    // the requester that was not granted last.
                    keep_owner = (burst_q != '0) && (burst_q < BURST_TOP);
                    if (tx_cand && rx_cand)
                        grant_owner = keep_owner ? owner_q
                                                 : ((owner_q == OWN_TX) ? OWN_RX : OWN_TX);
                    else
                        grant_owner = tx_cand ? OWN_TX : OWN_RX;

                    if ((grant_owner == owner_q) && (burst_q != '0))
                        burst_d = (burst_q == BURST_TOP) ? burst_q : burst_q + 1'b1;
                    else
                        burst_d = BW'(1);
                    owner_d = grant_owner;

                    if (grant_owner == OWN_TX) begin
                        tx_req  = 1'b1;
                        state_d = ST_TX_WAIT;
                    end else begin
                        rx_poll = 1'b1;
                        state_d = ST_RX_WAIT;
                    end
                end
            end
            ST_TX_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (link_tx_ok_i) begin
                    fifo_pop = 1'b1;
                    retry_d  = '0;
                    state_d  = ST_IDLE;
                end else if (link_tx_err_i || timed_out) begin
                    tx_fail = 1'b1;
                    state_d = ST_IDLE;
                    if (retry_q < RETRY_TOP) begin
                        retry_d = retry_q + 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        drop_d   = 1'b1;
                        retry_d  = '0;
                    end
                end
            end
            ST_RX_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (link_rx_rdy_i) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = link_rx_data_i;
                    state_d    = ST_IDLE;
                end else if (link_rx_err_i || timed_out) begin
                    rx_err_d = 1'b1;
                    rx_fail  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run_q      <= 1'b0;
            state_q    <= ST_IDLE;
            owner_q    <= OWN_RX;
            burst_q    <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            state_q    <= state_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            drop_q     <= drop_d;
        end
    end

    assign link_tx_rdy_o  = tx_req;
    assign link_rx_poll_o = rx_poll;
    assign link_tx_data_o = (tx_req || (state_q == ST_TX_WAIT)) ? fifo_head : '0;
    assign rx_valid_o     = rx_valid_q;
    assign rx_data_o      = rx_data_q;
    assign rx_err_o       = rx_err_q;
    assign tx_drop_o      = drop_q;

`ifdef FTDI_LINK_STATS_EN
    logic [STAT_W-1:0] txerr_cnt, rxerr_cnt, drop_cnt;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            txerr_cnt <= '0;
            rxerr_cnt <= '0;
            drop_cnt  <= '0;
        end else if (stats_clr_i) begin
            txerr_cnt <= '0;
            rxerr_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (tx_fail) txerr_cnt <= sat_inc(txerr_cnt);
            if (rx_fail) rxerr_cnt <= sat_inc(rxerr_cnt);
            if (drop_d)  drop_cnt  <= sat_inc(drop_cnt);
        end
    end

    assign stat_txerr_o = txerr_cnt;
    assign stat_rxerr_o = rxerr_cnt;
    assign stat_drop_o  = drop_cnt;
`else
    logic stats_unused;
    assign stats_unused = ^{stats_clr_i, tx_fail, rx_fail};
    assign stat_txerr_o = '0;
    assign stat_rxerr_o = '0;
    assign stat_drop_o  = '0;
`endif

endmodule

// File: tb/tb_ftdi_link_scheduler.sv
// Scoreboard bench for ftdi_link_scheduler: expected grants are queued as stimulus is driven
// and checked by a link model that also answers each request.
module tb_ftdi_link_scheduler;

    typedef enum int {R_OK, R_ERR, R_NONE} resp_t;
    typedef struct packed {
        logic       is_tx;
        logic [7:0] data;
    } grant_t;

`ifdef FTDI_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_data_i = '0;
    logic        tx_ready_o, tx_drop_o;
    logic        rx_req_i = 1'b0;
    logic        rx_valid_o, rx_err_o;
    logic [7:0]  rx_data_o;
    logic        link_tx_rdy_o, link_rx_poll_o;
    logic [7:0]  link_tx_data_o;
    logic        link_tx_ok_i = 1'b0, link_tx_err_i = 1'b0;
    logic        link_rx_rdy_i = 1'b0, link_rx_err_i = 1'b0;
    logic [7:0]  link_rx_data_i = '0;
    logic        link_busy_i = 1'b0;
    logic        stats_clr_i = 1'b0;
    logic [15:0] stat_txerr_o, stat_rxerr_o, stat_drop_o;

    ftdi_link_scheduler dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .tx_valid_i     (tx_valid_i),
        .tx_data_i      (tx_data_i),
        .tx_ready_o     (tx_ready_o),
        .tx_drop_o      (tx_drop_o),
        .rx_req_i       (rx_req_i),
        .rx_valid_o     (rx_valid_o),
        .rx_data_o      (rx_data_o),
        .rx_err_o       (rx_err_o),
        .link_tx_rdy_o  (link_tx_rdy_o),
        .link_tx_data_o (link_tx_data_o),
        .link_tx_ok_i   (link_tx_ok_i),
        .link_tx_err_i  (link_tx_err_i),
        .link_rx_poll_o (link_rx_poll_o),
        .link_rx_rdy_i  (link_rx_rdy_i),
        .link_rx_data_i (link_rx_data_i),
        .link_rx_err_i  (link_rx_err_i),
        .link_busy_i    (link_busy_i),
        .stats_clr_i    (stats_clr_i),
        .stat_txerr_o   (stat_txerr_o),
        .stat_rxerr_o   (stat_rxerr_o),
        .stat_drop_o    (stat_drop_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     drop_cnt = 0;
    int     rx_err_cnt = 0;
    int     poll_cyc = 0;
    int     rx_err_cyc = 0;
    resp_t  resp_mode = R_OK;
    grant_t exp_grant[$];
    logic [7:0] exp_rx[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Link model: answers each request one cycle after its pulse and scores grants/results.
    initial begin : link_model
        logic       due_tx = 1'b0;
        logic       due_rx = 1'b0;
        logic [7:0] rx_byte = 8'h3C;
        grant_t     g;
        forever begin
            @(posedge clk_i); #1;
            link_tx_ok_i  = 1'b0;
            link_tx_err_i = 1'b0;
            link_rx_rdy_i = 1'b0;
            link_rx_err_i = 1'b0;
            if (due_tx && resp_mode == R_OK)  link_tx_ok_i  = 1'b1;
            if (due_tx && resp_mode == R_ERR) link_tx_err_i = 1'b1;
            if (due_rx && resp_mode == R_OK) begin
                link_rx_rdy_i  = 1'b1;
                link_rx_data_i = rx_byte;
                exp_rx.push_back(rx_byte);
                rx_byte = rx_byte + 8'h11;
            end
            if (due_rx && resp_mode == R_ERR) link_rx_err_i = 1'b1;
            due_tx = 1'b0;
            due_rx = 1'b0;

            @(negedge clk_i);
            cyc++;
            if (link_tx_rdy_o || link_rx_poll_o) begin
                check("grant_expected", 32'(exp_grant.size() > 0), 32'd1);
                if (exp_grant.size() > 0) begin
                    g = exp_grant.pop_front();
                    check("grant_kind_tx", 32'(link_tx_rdy_o), 32'(g.is_tx));
                    if (g.is_tx) check("tx_link_byte", 32'(link_tx_data_o), 32'(g.data));
                end
                due_tx = link_tx_rdy_o;
                due_rx = link_rx_poll_o;
                if (link_rx_poll_o) poll_cyc = cyc;
            end
            if (rx_valid_o) begin
                check("rx_result_expected", 32'(exp_rx.size() > 0), 32'd1);
                if (exp_rx.size() > 0) check("rx_data", 32'(rx_data_o), 32'(exp_rx.pop_front()));
            end
            if (rx_err_o) begin
                rx_err_cnt++;
                rx_err_cyc = cyc;
            end
            if (tx_drop_o) drop_cnt++;
        end
    end

    task automatic exp_tx(input logic [7:0] b);
        exp_grant.push_back('{is_tx: 1'b1, data: b});
    endtask

    task automatic exp_rx_grant();
        exp_grant.push_back('{is_tx: 1'b0, data: 8'h00});
    endtask

    // Called and returns at posedge+1.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        tx_valid_i = 1'b1;
        tx_data_i  = b;
        @(negedge clk_i);
        while (!tx_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("push_accepted", 32'(tx_ready_o), 32'd1);
        @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_grant.size() > 0 && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk_i); #1;
        end
        check(tag, 32'(exp_grant.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        #1;
        check("rst_link_tx_rdy", 32'(link_tx_rdy_o), 32'd0);
        check("rst_link_tx_data", 32'(link_tx_data_o), 32'd0);
        check("rst_link_rx_poll", 32'(link_rx_poll_o), 32'd0);
        check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
        check("rst_outs", 32'({rx_valid_o, rx_err_o, tx_drop_o, rx_data_o}), 32'd0);
        check("rst_stats", 32'({stat_txerr_o | stat_rxerr_o | stat_drop_o}), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        @(negedge clk_i);
        check("rel_tx_ready_low", 32'(tx_ready_o), 32'd0);
        @(negedge clk_i);
        check("rel_tx_ready_high", 32'(tx_ready_o), 32'd1);
        @(posedge clk_i); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int drops_before;
        int errs_before;

        @(posedge clk_i); #1;
        do_reset();

        // TX only: two bytes issued in order, each acknowledged.
        resp_mode = R_OK;
        exp_tx(8'h81);
        exp_tx(8'h05);
        push_byte(8'h81);
        push_byte(8'h05);
        wait_drain("t1_drain", 200);
        check("t1_tx_ready", 32'(tx_ready_o), 32'd1);

        // Contention from reset: TX wins the first tie, bursts of two alternate.
        do_reset();
        link_busy_i = 1'b1;
        push_byte(8'hA0);
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        @(negedge clk_i);
        check("t2_full_ready", 32'(tx_ready_o), 32'd0);
        @(posedge clk_i); #1;
        exp_tx(8'hA0);
        exp_tx(8'hA1);
        exp_rx_grant();
        exp_rx_grant();
        exp_tx(8'hA2);
        exp_tx(8'hA3);
        rx_req_i    = 1'b1;
        link_busy_i = 1'b0;
        n = 0;
        while (exp_grant.size() > 1 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        rx_req_i = 1'b0;
        wait_drain("t2_drain", 200);
        check("t2_rx_all_delivered", 32'(exp_rx.size()), 32'd0);

        // Retry: three errors on one byte give three issues and a single drop.
        resp_mode    = R_ERR;
        drops_before = drop_cnt;
        exp_tx(8'hA5);
        exp_tx(8'hA5);
        exp_tx(8'hA5);
        push_byte(8'hA5);
        wait_drain("t3_drain", 200);
        check("t3_drop_once", 32'(drop_cnt - drops_before), 32'd1);
        check("t3_stat_txerr", 32'(stat_txerr_o), STATS ? 32'd3 : 32'd0);
        check("t3_stat_drop", 32'(stat_drop_o), STATS ? 32'd1 : 32'd0);

        // Timeout: unanswered poll errors on cycle 1025 after its pulse; requester drops early.
        resp_mode   = R_NONE;
        errs_before = rx_err_cnt;
        exp_rx_grant();
        rx_req_i = 1'b1;
        n = 0;
        while (exp_grant.size() > 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        rx_req_i = 1'b0;
        n = 0;
        while (rx_err_cnt == errs_before && n < 1200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("t4_rx_err_once", 32'(rx_err_cnt - errs_before), 32'd1);
        check("t4_timeout_cycle", 32'(rx_err_cyc - poll_cyc), 32'd1025);
        check("t4_stat_rxerr", 32'(stat_rxerr_o), STATS ? 32'd1 : 32'd0);
        stats_clr_i = 1'b1;
        @(posedge clk_i); #1;
        stats_clr_i = 1'b0;
        check("t4_stats_cleared", 32'({stat_txerr_o | stat_rxerr_o | stat_drop_o}), 32'd0);

        // Full queue with the link held busy: the fifth byte waits, none lost.
        resp_mode   = R_OK;
        link_busy_i = 1'b1;
        push_byte(8'hB0);
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'hB4;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check("t5_ready_low_full", 32'(tx_ready_o), 32'd0);
        @(posedge clk_i); #1;
        exp_tx(8'hB0);
        exp_tx(8'hB1);
        exp_tx(8'hB2);
        exp_tx(8'hB3);
        exp_tx(8'hB4);
        link_busy_i = 1'b0;
        push_byte(8'hB4);
        wait_drain("t5_drain", 200);

        // Reset while waiting on a TX response: transaction abandoned, no drop.
        resp_mode    = R_NONE;
        drops_before = drop_cnt;
        exp_tx(8'hC0);
        push_byte(8'hC0);
        n = 0;
        while (exp_grant.size() > 0 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        repeat (3) @(posedge clk_i);
        #1;
        check("t6_data_before_rst", 32'(link_tx_data_o), 32'hC0);
        do_reset();
        resp_mode = R_OK;
        repeat (20) @(posedge clk_i);
        #1;
        check("t6_no_drop", 32'(drop_cnt - drops_before), 32'd0);
        check("t6_queue_empty", 32'(exp_grant.size()), 32'd0);
        check("t6_tx_ready", 32'(tx_ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
